// File: rtl/conv_scheduler.sv
// conv_scheduler: steps one float16 convolution across output channels,
// result rows and result columns. For each window it drives the buffer
// anchors, hands the window to the MAC with cal_valid/cal_ready, strobes
// result_we on mac_done, and pulses done after the last result.
// Optional build macro: CONV_SCHED_PERF_EN adds the perf_cycles and
// stall_cycles counter ports.
module conv_scheduler #(
    parameter int data_width     = 16,
    parameter int output_channel = 1,
    parameter int result_length  = 2,
    parameter int result_width   = 2,
    parameter int stride         = 1,
    parameter int BUF_LAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conv_en,
    output logic [data_width-1:0] archor_2D,
    output logic [data_width-1:0] archor_1D,
    output logic [data_width-1:0] wsel,
    output logic                  cal_valid,
    input  logic                  cal_ready,
    input  logic                  mac_done,
    output logic                  result_we,
    output logic [data_width-1:0] res_ch,
    output logic [data_width-1:0] res_row,
    output logic [data_width-1:0] res_col,
    output logic                  busy,
    output logic                  done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [data_width-1:0] CH_MAX   = data_width'(output_channel - 1);
    localparam logic [data_width-1:0] ROW_MAX  = data_width'(result_length - 1);
    localparam logic [data_width-1:0] COL_MAX  = data_width'(result_width - 1);
    localparam logic [data_width-1:0] STRIDE_W = data_width'(stride);
    localparam logic [15:0]           LAT_LAST = 16'(BUF_LAT - 1);

    logic [2:0]            state;
    logic [data_width-1:0] ch_q;
    logic [data_width-1:0] row_q;
    logic [data_width-1:0] col_q;
    logic [15:0]           lat_cnt;
    logic                  last_win;

    assign last_win = (ch_q == CH_MAX) && (row_q == ROW_MAX) && (col_q == COL_MAX);

    // Sequencing FSM plus index walk; abort (conv_en low) overrides every other move
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            lat_cnt <= '0;
        end else if (state != S_IDLE && !conv_en) begin
            state   <= S_IDLE;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (conv_en) begin
                        state   <= S_LOAD;
                        lat_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= S_ISSUE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 16'd1;
                    end
                end
                S_ISSUE: begin
                    if (cal_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mac_done) begin
                        lat_cnt <= '0;
                        if (last_win) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_LOAD;
                            if (col_q == COL_MAX) begin
                                col_q <= '0;
                                if (row_q == ROW_MAX) begin
                                    row_q <= '0;
                                    ch_q  <= ch_q + 1'b1;
                                end else begin
                                    row_q <= row_q + 1'b1;
                                end
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    ch_q  <= '0;
                    row_q <= '0;
                    col_q <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from state; conv_en gating lets an abort suppress them in its own cycle
    always_comb begin
        cal_valid = (state == S_ISSUE);
        result_we = (state == S_WAIT) && mac_done && conv_en;
        done      = (state == S_FIN) && conv_en;
        busy      = (state != S_IDLE);
        res_ch    = ch_q;
        res_row   = row_q;
        res_col   = col_q;
        wsel      = ch_q;
        archor_2D = row_q * STRIDE_W;
        archor_1D = col_q * STRIDE_W;
    end

`ifdef CONV_SCHED_PERF_EN
    // Run-length and MAC back-pressure counters; cleared at start, held after the run ends
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_cycles  <= '0;
            stall_cycles <= '0;
        end else if (state == S_IDLE && conv_en) begin
            perf_cycles  <= '0;
            stall_cycles <= '0;
        end else if (state != S_IDLE) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (state == S_ISSUE && !cal_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: two instances (defaults, and stride 2 with two output
// channels). Expected result coordinates come from a hand-written table and
// are queued when a run is started; a negedge monitor pops them on result_we.
module tb_conv_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en   [2];
    logic        rdy  [2];
    logic        md   [2];
    logic [15:0] a2   [2];
    logic [15:0] a1   [2];
    logic [15:0] ws   [2];
    logic [15:0] rc   [2];
    logic [15:0] rr   [2];
    logic [15:0] rcol [2];
    logic        cv   [2];
    logic        we   [2];
    logic        busy [2];
    logic        dn   [2];
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf0, stall0, perf1, stall1;
`endif

    conv_scheduler u0 (
        .clk(clk), .reset(rst_n), .conv_en(en[0]),
        .archor_2D(a2[0]), .archor_1D(a1[0]), .wsel(ws[0]),
        .cal_valid(cv[0]), .cal_ready(rdy[0]), .mac_done(md[0]),
        .result_we(we[0]), .res_ch(rc[0]), .res_row(rr[0]), .res_col(rcol[0]),
        .busy(busy[0]), .done(dn[0])
`ifdef CONV_SCHED_PERF_EN
        , .perf_cycles(perf0), .stall_cycles(stall0)
`endif
    );

    conv_scheduler #(.output_channel(2), .stride(2)) u1 (
        .clk(clk), .reset(rst_n), .conv_en(en[1]),
        .archor_2D(a2[1]), .archor_1D(a1[1]), .wsel(ws[1]),
        .cal_valid(cv[1]), .cal_ready(rdy[1]), .mac_done(md[1]),
        .result_we(we[1]), .res_ch(rc[1]), .res_row(rr[1]), .res_col(rcol[1]),
        .busy(busy[1]), .done(dn[1])
`ifdef CONV_SCHED_PERF_EN
        , .perf_cycles(perf1), .stall_cycles(stall1)
`endif
    );

    typedef struct {
        int dut;
        int ch;
        int row;
        int col;
        int x2;
        int x1;
    } vec_t;

    vec_t vecs [12];
    vec_t sb0 [$];
    vec_t sb1 [$];

    int checks = 0;
    int errors = 0;
    int we_cnt   [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int busy_cnt [2] = '{0, 0};
    logic prev_done [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vecs(input int d);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].dut == d) begin
                if (d == 0) sb0.push_back(vecs[i]);
                else        sb1.push_back(vecs[i]);
            end
        end
    endtask

    // Scoreboard monitor: sampled at negedge, away from the active edge
    always @(negedge clk) begin
        vec_t e;
        for (int d = 0; d < 2; d++) begin
            if (we[d] === 1'b1) begin
                we_cnt[d]++;
                if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                    chk("unexpected_result_we", 1, 0);
                end else begin
                    if (d == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    chk("res_ch",    rc[d],   e.ch);
                    chk("res_row",   rr[d],   e.row);
                    chk("res_col",   rcol[d], e.col);
                    chk("wsel",      ws[d],   e.ch);
                    chk("archor_2D", a2[d],   e.x2);
                    chk("archor_1D", a1[d],   e.x1);
                end
            end
            if (prev_done[d]) chk("busy_after_done", busy[d], 0);
            prev_done[d] = (dn[d] === 1'b1);
            if (dn[d] === 1'b1) done_cnt[d]++;
            if (busy[d] === 1'b1) busy_cnt[d]++;
        end
    end

    // MAC model: optional ready stall per window, mac_done mac_lat cycles after handshake
    task automatic auto_run(input int d, input int mac_lat, input int stall_len,
                            output int stalls);
        int  cd;
        int  sl;
        int  guard;
        bit  fin;
        cd = 0; sl = stall_len; guard = 0; fin = 0; stalls = 0;
        en[d] = 1'b1; rdy[d] = 1'b1; md[d] = 1'b0;
        while (!fin && guard < 400) begin
            step();
            guard++;
            if (dn[d] === 1'b1) fin = 1;
            md[d] = 1'b0;
            if (cd > 0) begin
                cd--;
                md[d] = (cd == 0);
            end
            if (cv[d] === 1'b1) begin
                if (sl > 0) begin
                    rdy[d] = 1'b0;
                    sl--;
                    stalls++;
                end else begin
                    rdy[d] = 1'b1;
                    cd = mac_lat;
                    sl = stall_len;
                end
            end else begin
                rdy[d] = 1'b1;
            end
        end
        chk("run_completes", fin, 1);
        step();
        en[d] = 1'b0;
        md[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        int g;
        g = 0;
        while (cv[d] !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk("reach_issue", cv[d], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   st;
        int   sw;
        int   sd;
        logic [15:0] s2, s1;

        vecs[0]  = '{0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 1};
        vecs[2]  = '{0, 0, 1, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 1, 1, 1};
        vecs[4]  = '{1, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 1, 0, 2};
        vecs[6]  = '{1, 0, 1, 0, 2, 0};
        vecs[7]  = '{1, 0, 1, 1, 2, 2};
        vecs[8]  = '{1, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, 0, 2};
        vecs[10] = '{1, 1, 1, 0, 2, 0};
        vecs[11] = '{1, 1, 1, 1, 2, 2};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; rdy[d] = 1'b0; md[d] = 1'b0;
        end
        repeat (3) step();

        // reset state
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", busy[d], 0);
            chk("reset_outputs",
                {cv[d], we[d], dn[d], a2[d], a1[d], ws[d], rc[d], rr[d], rcol[d]}, 0);
        end
        rst_n = 1'b1;
        step();

        // 1: defaults, mac_done two cycles after handshake
        we_cnt[0] = 0; done_cnt[0] = 0;
        push_vecs(0);
        auto_run(0, 2, 0, st);
        chk("t1_sb_empty", sb0.size(), 0);
        chk("t1_result_we", we_cnt[0], 4);
        chk("t1_done", done_cnt[0], 1);
        chk("t1_idle", busy[0], 0);

        // 2: stride 2, two output channels
        we_cnt[1] = 0; done_cnt[1] = 0;
        push_vecs(1);
        auto_run(1, 1, 0, st);
        chk("t2_sb_empty", sb1.size(), 0);
        chk("t2_result_we", we_cnt[1], 8);
        chk("t2_done", done_cnt[1], 1);

        // 3: ready held low five cycles in ISSUE of window 2
        sb0.push_back(vecs[0]);
        en[0] = 1'b1; rdy[0] = 1'b1;
        wait_valid(0);
        step();
        md[0] = 1'b1;
        step();
        md[0] = 1'b0; rdy[0] = 1'b0;
        wait_valid(0);
        s2 = a2[0]; s1 = a1[0];
        chk("t3_anchor2d", s2, 0);
        chk("t3_anchor1d", s1, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid_held", cv[0], 1);
            chk("t3_anchor2d_stable", a2[0], s2);
            chk("t3_anchor1d_stable", a1[0], s1);
            chk("t3_col_stable", rcol[0], 1);
        end
        rdy[0] = 1'b1;
        step();
        chk("t3_valid_drops", cv[0], 0);
        en[0] = 1'b0;
        step();
        chk("t3_abort_idle", busy[0], 0);
        chk("t3_sb_empty", sb0.size(), 0);

        // 4: abort in WAIT of window 2 with mac_done in the same cycle
        sb0.push_back(vecs[0]);
        done_cnt[0] = 0;
        en[0] = 1'b1; rdy[0] = 1'b1;
        wait_valid(0);
        step();
        md[0] = 1'b1;
        step();
        md[0] = 1'b0;
        wait_valid(0);
        step();
        chk("t4_in_wait", cv[0], 0);
        en[0] = 1'b0; md[0] = 1'b1;
        sw = we_cnt[0]; sd = done_cnt[0];
        step();
        md[0] = 1'b0;
        chk("t4_busy", busy[0], 0);
        chk("t4_no_result_we", we_cnt[0], sw);
        chk("t4_no_done", done_cnt[0], sd);
        chk("t4_col_cleared", rcol[0], 0);
        chk("t4_sb_empty", sb0.size(), 0);
        step();
        chk("t4_stays_idle", busy[0], 0);

        // 5: reset asserted mid-LOAD, released with conv_en still high
        en[0] = 1'b1; rdy[0] = 1'b1;
        step();
        chk("t5_in_load", busy[0], 1);
        rst_n = 1'b0;
        step();
        chk("t5_reset_busy", busy[0], 0);
        chk("t5_reset_outputs",
            {cv[0], we[0], dn[0], a2[0], a1[0], ws[0], rc[0], rr[0], rcol[0]}, 0);
        rst_n = 1'b1;
        we_cnt[0] = 0; done_cnt[0] = 0;
        push_vecs(0);
        auto_run(0, 2, 0, st);
        chk("t5_sb_empty", sb0.size(), 0);
        chk("t5_result_we", we_cnt[0], 4);
        chk("t5_done", done_cnt[0], 1);

`ifdef CONV_SCHED_PERF_EN
        // 6: performance counters
        busy_cnt[0] = 0;
        push_vecs(0);
        auto_run(0, 1, 0, st);
        chk("t6_perf_busy", perf0, busy_cnt[0]);
        chk("t6_perf_const", perf0, 13);
        chk("t6_stall_zero", stall0, 0);
        busy_cnt[0] = 0;
        push_vecs(0);
        auto_run(0, 1, 3, st);
        chk("t6_stall_total", st, 12);
        chk("t6_perf_busy_stall", perf0, busy_cnt[0]);
        chk("t6_stall_count", stall0, st);
        step();
        chk("t6_perf_hold", perf0, busy_cnt[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
